tx_req_arbiter: RTL and testbench

Shares the single PCIe TX engine between two requesters:
- the completion path (CPL/CPLD from the command-process FSM);
- the upstream memory-write path (MWr toward host memory).

The block latches the granted requester's packed descriptor and holds the TX request until the engine reports done. It then returns a done pulse to the winner. Arbitration is round-robin, with a consecutive-grant limit.

---
 rtl/tx_arb_pkg.sv | 32 +++
 rtl/tx_req_arbiter_rr2_pick.sv | 33 +++
 rtl/tx_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_tx_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared definitions for the TX request arbiter: FSM encoding, requester IDs
// and the descriptor field layout used when packing and unpacking requests.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Requester IDs; also the value driven on txe_is_cpl_o.
    localparam logic REQ_CPL = 1'b1;
    localparam logic REQ_MWR = 1'b0;

    // Packed descriptor layout (96 bits). For a write, ADDR holds the host
    // address and the RID/TAG bits carry the local address high part.
    localparam int DESC_ADDR_LSB = 0;
    localparam int DESC_ADDR_W   = 64;
    localparam int DESC_BE_LSB   = 64;
    localparam int DESC_BE_W     = 8;
    localparam int DESC_TAG_LSB  = 72;
    localparam int DESC_TAG_W    = 8;
    localparam int DESC_LEN_LSB  = 80;
    localparam int DESC_LEN_W    = 10;
    localparam int DESC_ATTR_LSB = 90;
    localparam int DESC_ATTR_W   = 2;
    localparam int DESC_EP_LSB   = 92;
    localparam int DESC_TD_LSB   = 93;
    localparam int DESC_TC_LSB   = 94;
    localparam int DESC_TC_W     = 2;

endpackage

// File: rtl/tx_req_arbiter_rr2_pick.sv
// Two-way round-robin pick with a consecutive-grant limit. Purely combinational.
// reqs[1] is the completion path, reqs[0] the upstream write path.
module rr2_pick
    import tx_arb_pkg::*;
#(
    parameter int MAX_CONSEC = 4,
    parameter int CONSEC_W   = 3
) (
    input  logic [1:0]          reqs,
    input  logic                last_grant,
    input  logic [CONSEC_W-1:0] consec,
    input  logic                last_solo,
    output logic                winner,
    output logic                valid
);

    // Under contention the previous winner may repeat only if it was alone
    // last time and has not yet used up its consecutive allowance.
    always_comb begin
        valid  = |reqs;
        winner = REQ_MWR;
        if (reqs == 2'b11) begin
            if (last_solo && (consec < CONSEC_W'(MAX_CONSEC))) begin
                winner = last_grant;
            end else begin
                winner = ~last_grant;
            end
        end else if (reqs[1]) begin
            winner = REQ_CPL;
        end
    end

endmodule

// File: rtl/tx_req_arbiter.sv
// Shares the PCIe TX engine between the completion path and the upstream
// memory-write path. Latches the winner's descriptor, holds txe_req_o until
// txe_done_i, then pulses the winner's done in a one-cycle RELEASE state.
// Optional watchdog: define TX_ARB_WATCHDOG_EN to abort stuck BUSY phases
// after TIMEOUT_CYC cycles.
module tx_req_arbiter
    import tx_arb_pkg::*;
#(
    parameter int DESC_W      = 96,
    parameter int MAX_CONSEC  = 4,
    parameter int CNT_W       = 16
`ifdef TX_ARB_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpl_req_i,
    input  logic [DESC_W-1:0] cpl_desc_i,
    output logic              cpl_done_o,
    input  logic              mwr_req_i,
    input  logic [DESC_W-1:0] mwr_desc_i,
    output logic              mwr_done_o,
    output logic              txe_req_o,
    output logic              txe_is_cpl_o,
    output logic [DESC_W-1:0] txe_desc_o,
    input  logic              txe_done_i,
    output logic              abort_o,
    output logic              timeout_err_o,
    output logic [CNT_W-1:0]  cpl_cnt_o,
    output logic [CNT_W-1:0]  mwr_cnt_o,
    output arb_state_e        dbg_state_o
);

    localparam int CONSEC_W = $clog2(MAX_CONSEC + 1);

    arb_state_e          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                last_solo_q, last_solo_d;
    logic [CONSEC_W-1:0] consec_q, consec_d;
    logic                is_cpl_q, is_cpl_d;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic [CNT_W-1:0]    cpl_cnt_q, cpl_cnt_d;
    logic [CNT_W-1:0]    mwr_cnt_q, mwr_cnt_d;
    logic                pick_winner, pick_valid, grant, timeout_hit;

    rr2_pick #(
        .MAX_CONSEC (MAX_CONSEC),
        .CONSEC_W   (CONSEC_W)
    ) u_pick (
        .reqs       ({cpl_req_i, mwr_req_i}),
        .last_grant (last_grant_q),
        .consec     (consec_q),
        .last_solo  (last_solo_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Requests are only looked at in IDLE.
    assign grant = (state_q == ST_IDLE) && pick_valid;

`ifdef TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            abort_q, abort_d;
    logic            err_q, err_d;

    // wd_q counts completed BUSY cycles, so it equals TIMEOUT_CYC-1 during the
    // TIMEOUT_CYC-th BUSY cycle.
    assign timeout_hit = (state_q == ST_BUSY) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog counter plus abort/error bookkeeping; a real done beats a timeout.
    always_comb begin
        wd_d    = wd_q;
        abort_d = abort_q;
        err_d   = err_q;
        if (grant) begin
            wd_d    = '0;
            abort_d = 1'b0;
        end else if (state_q == ST_BUSY) begin
            wd_d = wd_q + WD_W'(1);
            if (timeout_hit && !txe_done_i) begin
                abort_d = 1'b1;
                err_d   = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign abort_o       = (state_q == ST_RELEASE) && abort_q;
    assign timeout_err_o = err_q;
`else
    assign timeout_hit   = 1'b0;
    assign abort_o       = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Next-state, grant bookkeeping and descriptor latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        last_solo_d  = last_solo_q;
        consec_d     = consec_q;
        is_cpl_d     = is_cpl_q;
        desc_d       = desc_q;
        cpl_cnt_d    = cpl_cnt_q;
        mwr_cnt_d    = mwr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d      = ST_BUSY;
                    is_cpl_d     = pick_winner;
                    desc_d       = (pick_winner == REQ_CPL) ? cpl_desc_i : mwr_desc_i;
                    last_grant_d = pick_winner;
                    last_solo_d  = !(cpl_req_i && mwr_req_i);
                    if (pick_winner != last_grant_q) begin
                        consec_d = CONSEC_W'(1);
                    end else if (consec_q < CONSEC_W'(MAX_CONSEC)) begin
                        consec_d = consec_q + CONSEC_W'(1);
                    end
                    if (pick_winner == REQ_CPL) begin
                        cpl_cnt_d = cpl_cnt_q + CNT_W'(1);
                    end else begin
                        mwr_cnt_d = mwr_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (txe_done_i || timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_MWR;
            last_solo_q  <= 1'b0;
            consec_q     <= '0;
            is_cpl_q     <= 1'b0;
            desc_q       <= '0;
            cpl_cnt_q    <= '0;
            mwr_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            last_solo_q  <= last_solo_d;
            consec_q     <= consec_d;
            is_cpl_q     <= is_cpl_d;
            desc_q       <= desc_d;
            cpl_cnt_q    <= cpl_cnt_d;
            mwr_cnt_q    <= mwr_cnt_d;
        end
    end

    assign txe_req_o    = (state_q == ST_BUSY);
    assign cpl_done_o   = (state_q == ST_RELEASE) && (is_cpl_q == REQ_CPL);
    assign mwr_done_o   = (state_q == ST_RELEASE) && (is_cpl_q == REQ_MWR);
    assign txe_is_cpl_o = is_cpl_q;
    assign txe_desc_o   = desc_q;
    assign cpl_cnt_o    = cpl_cnt_q;
    assign mwr_cnt_o    = mwr_cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tx_req_arbiter.sv
// Bench for tx_req_arbiter: table-driven arbitration sequence, grant
// scoreboard, and hand-written reset / spurious-done / stall sequences.
module tb_tx_req_arbiter;
    import tx_arb_pkg::*;

    localparam int DESC_W     = 96;
    localparam int CNT_W      = 4;
    localparam int MAX_CONSEC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpl_req_i = 1'b0;
    logic [DESC_W-1:0] cpl_desc_i = '0;
    logic              cpl_done_o;
    logic              mwr_req_i = 1'b0;
    logic [DESC_W-1:0] mwr_desc_i = '0;
    logic              mwr_done_o;
    logic              txe_req_o;
    logic              txe_is_cpl_o;
    logic [DESC_W-1:0] txe_desc_o;
    logic              txe_done_i = 1'b0;
    logic              abort_o;
    logic              timeout_err_o;
    logic [CNT_W-1:0]  cpl_cnt_o;
    logic [CNT_W-1:0]  mwr_cnt_o;
    arb_state_e        dbg_state;

    int tests = 0;
    int fails = 0;
    int exp_cpl_cnt = 0;
    int exp_mwr_cnt = 0;
    logic [DESC_W:0] exp_q[$];
    logic [DESC_W:0] last_exp;
    logic prev_req = 1'b0;

    typedef struct {
        logic c;
        logic m;
        logic exp_cpl;
    } vec_t;
    vec_t vecs[24];

    tx_req_arbiter #(
        .DESC_W      (DESC_W),
        .MAX_CONSEC  (MAX_CONSEC),
        .CNT_W       (CNT_W)
`ifdef TX_ARB_WATCHDOG_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpl_req_i     (cpl_req_i),
        .cpl_desc_i    (cpl_desc_i),
        .cpl_done_o    (cpl_done_o),
        .mwr_req_i     (mwr_req_i),
        .mwr_desc_i    (mwr_desc_i),
        .mwr_done_o    (mwr_done_o),
        .txe_req_o     (txe_req_o),
        .txe_is_cpl_o  (txe_is_cpl_o),
        .txe_desc_o    (txe_desc_o),
        .txe_done_i    (txe_done_i),
        .abort_o       (abort_o),
        .timeout_err_o (timeout_err_o),
        .cpl_cnt_o     (cpl_cnt_o),
        .mwr_cnt_o     (mwr_cnt_o),
        .dbg_state_o   (dbg_state)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    function automatic logic [DESC_W-1:0] rnd_desc();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rising txe_req_o must match the oldest expected grant.
    always @(negedge clk) begin
        if (txe_req_o && !prev_req) begin
            check("grant_pending", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                last_exp = exp_q.pop_front();
                check("grant_is_cpl", 128'(txe_is_cpl_o), 128'(last_exp[DESC_W]));
                check("grant_desc", 128'(txe_desc_o), 128'(last_exp[DESC_W-1:0]));
            end
        end
        prev_req <= txe_req_o;
    end

    task automatic push_exp(input logic is_cpl);
        exp_q.push_back({is_cpl, is_cpl ? cpl_desc_i : mwr_desc_i});
        if (is_cpl) exp_cpl_cnt++;
        else        exp_mwr_cnt++;
    endtask

    // Waits (bounded) for txe_req_o; returns negedges elapsed.
    task automatic wait_grant(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!txe_req_o && lat < 8);
        if (!txe_req_o) check("grant_wait_expired", 128'(txe_req_o), 128'(1));
    endtask

    // Drives one request pattern, completes the winning packet after dly BUSY cycles.
    task automatic grant_cycle(input logic c, input logic m, input logic exp_cpl,
                               input int dly, input int exp_lat);
        int lat;
        if (!cpl_req_i) cpl_desc_i = rnd_desc();
        if (!mwr_req_i) mwr_desc_i = rnd_desc();
        cpl_req_i = c;
        mwr_req_i = m;
        push_exp(exp_cpl);
        wait_grant(lat);
        check("grant_latency", 128'(lat), 128'(exp_lat));
        repeat (dly) @(negedge clk);
        txe_done_i = 1'b1;
        @(negedge clk);
        txe_done_i = 1'b0;
        check("cpl_done", 128'(cpl_done_o), 128'(exp_cpl));
        check("mwr_done", 128'(mwr_done_o), 128'(!exp_cpl));
        check("done_no_abort", 128'(abort_o), 128'(0));
        check("req_dropped", 128'(txe_req_o), 128'(0));
        if (exp_cpl) cpl_desc_i = rnd_desc();
        else         mwr_desc_i = rnd_desc();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cpl_cnt"}, 128'(cpl_cnt_o), 128'(exp_cpl_cnt % (1 << CNT_W)));
        check({tag, "_mwr_cnt"}, 128'(mwr_cnt_o), 128'(exp_mwr_cnt % (1 << CNT_W)));
    endtask

    initial begin
        int lat;
        // Test 2: both held, alternation from reset (last_grant = MWR).
        for (int i = 0; i < 10; i++) vecs[i] = '{c: 1'b1, m: 1'b1, exp_cpl: (i % 2 == 0)};
        // Test 3: MWR alone six times (saturates consec), then contention.
        for (int i = 10; i < 16; i++) vecs[i] = '{c: 1'b0, m: 1'b1, exp_cpl: 1'b0};
        vecs[16] = '{c: 1'b1, m: 1'b1, exp_cpl: 1'b1};
        vecs[17] = '{c: 1'b1, m: 1'b1, exp_cpl: 1'b0};
        vecs[18] = '{c: 1'b1, m: 1'b1, exp_cpl: 1'b1};
        vecs[19] = '{c: 1'b1, m: 1'b1, exp_cpl: 1'b0};
        // Solo CPL twice, then contention: CPL may repeat once, then MWR.
        vecs[20] = '{c: 1'b1, m: 1'b0, exp_cpl: 1'b1};
        vecs[21] = '{c: 1'b1, m: 1'b0, exp_cpl: 1'b1};
        vecs[22] = '{c: 1'b1, m: 1'b1, exp_cpl: 1'b1};
        vecs[23] = '{c: 1'b1, m: 1'b1, exp_cpl: 1'b0};

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_txe_req", 128'(txe_req_o), 128'(0));
        check("rst_desc", 128'(txe_desc_o), 128'(0));
        check("rst_is_cpl", 128'(txe_is_cpl_o), 128'(0));
        check("rst_dones", 128'({cpl_done_o, mwr_done_o, abort_o, timeout_err_o}), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        check_counts("rst");
        rst = 1'b0;
        @(negedge clk);

        // Test 1: single CPL, done at T5, pulse at T6.
        cpl_desc_i = {12{8'hA5}};
        cpl_req_i  = 1'b1;
        push_exp(1'b1);
        wait_grant(lat);
        check("t1_latency", 128'(lat), 128'(1));
        check("t1_is_cpl", 128'(txe_is_cpl_o), 128'(1));
        check("t1_desc", 128'(txe_desc_o), 128'({12{8'hA5}}));
        repeat (4) @(negedge clk);
        check("t1_no_early_done", 128'(cpl_done_o), 128'(0));
        txe_done_i = 1'b1;
        @(negedge clk);
        txe_done_i = 1'b0;
        check("t1_cpl_done", 128'(cpl_done_o), 128'(1));
        check("t1_txe_req_low", 128'(txe_req_o), 128'(0));
        check_counts("t1");
        cpl_req_i = 1'b0;

        // Test 5: reset while BUSY.
        mwr_desc_i = rnd_desc();
        mwr_req_i  = 1'b1;
        push_exp(1'b0);
        wait_grant(lat);
        check("t5_latency", 128'(lat), 128'(2));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_txe_req", 128'(txe_req_o), 128'(0));
        check("t5_state", 128'(dbg_state), 128'(ST_IDLE));
        check("t5_desc", 128'(txe_desc_o), 128'(0));
        exp_cpl_cnt = 0;
        exp_mwr_cnt = 0;
        check_counts("t5");
        mwr_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Tests 2 and 3 from the table; first entry starts from IDLE.
        for (int i = 0; i < 24; i++) begin
            grant_cycle(vecs[i].c, vecs[i].m, vecs[i].exp_cpl,
                        $urandom_range(0, 3), (i == 0) ? 1 : 2);
            if (i == 9) check_counts("t2");
        end
        check_counts("t3");

        // Test 4: spurious done in IDLE, requester drop in BUSY, done held into RELEASE.
        cpl_req_i = 1'b0;
        mwr_req_i = 1'b0;
        @(negedge clk);
        txe_done_i = 1'b1;
        @(negedge clk);
        txe_done_i = 1'b0;
        check("t4_spur_dones", 128'({cpl_done_o, mwr_done_o}), 128'(0));
        check("t4_spur_state", 128'(dbg_state), 128'(ST_IDLE));
        @(negedge clk);
        mwr_desc_i = rnd_desc();
        mwr_req_i  = 1'b1;
        push_exp(1'b0);
        wait_grant(lat);
        check("t4_latency", 128'(lat), 128'(1));
        mwr_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_held", 128'(txe_req_o), 128'(1));
        txe_done_i = 1'b1;
        @(negedge clk);
        check("t4_mwr_done", 128'({cpl_done_o, mwr_done_o}), 128'(2'b01));
        @(negedge clk);
        txe_done_i = 1'b0;
        check("t4_single_pulse", 128'({cpl_done_o, mwr_done_o}), 128'(0));
        check("t4_idle", 128'(dbg_state), 128'(ST_IDLE));
        check("t4_desc_hold", 128'(txe_desc_o), 128'(last_exp[DESC_W-1:0]));
        check("t4_is_cpl_hold", 128'(txe_is_cpl_o), 128'(0));
        check_counts("t4");

        // Done on the 16th BUSY cycle completes normally.
        grant_cycle(1'b1, 1'b0, 1'b1, 15, 1);
        check("t6_no_err", 128'(timeout_err_o), 128'(0));
        cpl_req_i = 1'b0;

        // Stall: no txe_done_i.
        mwr_desc_i = rnd_desc();
        mwr_req_i  = 1'b1;
        push_exp(1'b0);
        wait_grant(lat);
`ifdef TX_ARB_WATCHDOG_EN
        repeat (16) @(negedge clk);
        check("t6_abort_done", 128'({mwr_done_o, abort_o, timeout_err_o}), 128'(3'b111));
        check("t6_abort_req", 128'(txe_req_o), 128'(0));
        mwr_req_i = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_err_sticky", 128'({timeout_err_o, abort_o, mwr_done_o}), 128'(3'b100));
`else
        repeat (40) @(negedge clk);
        check("t6_stall_held", 128'(txe_req_o), 128'(1));
        check("t6_stall_flags", 128'({abort_o, timeout_err_o}), 128'(0));
        txe_done_i = 1'b1;
        @(negedge clk);
        txe_done_i = 1'b0;
        check("t6_stall_done", 128'({mwr_done_o, abort_o}), 128'(2'b10));
        mwr_req_i = 1'b0;
        @(negedge clk);
`endif
        check_counts("end");
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
